xyolo_write_ctrl: RTL and testbench

- Internal sequencer for the YOLO write stage.
- Each job drives the stage's internal-side controls: vread memory read port (vread_enB/vread_addrB), xyolo load strobes (ld_acc, ld_mp, ld_res) and vwrite memory write port (vwrite_enB/vwrite_addrB).
- Streams taps*outputs pixels into the xyolo vector and writes each accumulation result, or each 4-result maxpool window, into the vwrite memories.
- Sits beside the stage; the external ext_addrgen transfers are started separately by global_run.

---
 rtl/xyolo_write_ctrl_pkg.sv | 22 ++
 rtl/xyolo_ctrl_dly.sv | 23 ++
 rtl/xyolo_write_ctrl.sv | 144 ++++++++++++++
 tb/tb_xyolo_write_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/xyolo_write_ctrl_pkg.sv
// Shared constants, FSM encoding and per-read tag layout for the YOLO write-stage sequencer.
package xyolo_write_ctrl_pkg;
    localparam int RD_LAT_DEF = 2;
    localparam int WR_LAT_DEF = 3;
    localparam int MP_WIN     = 4;
    localparam int MP_IDX_W   = $clog2(MP_WIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Travels with each read so strobes line up with the pixel at the xyolo input.
    typedef struct packed {
        logic fin;   // last read of the job
        logic wr;    // this accumulation produces a write
        logic mp;    // maxpool window start
        logic res;   // last tap
        logic acc;   // first tap
    } tag_t;
endpackage

// File: rtl/xyolo_ctrl_dly.sv
// DEPTH x WIDTH shift register with asynchronous clear; output is the oldest stage.
module xyolo_ctrl_dly #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/xyolo_write_ctrl.sv
// YOLO write-stage sequencer: streams taps*outputs vread reads, aligns xyolo load
// strobes to the read latency and issues vwrite writes per accumulation or maxpool window.
module xyolo_write_ctrl
    import xyolo_write_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_W    = 11,
    parameter int VWRITE_ADDR_W = 8,
    parameter int CNT_W         = 12,
    parameter int RD_LAT        = RD_LAT_DEF,
    parameter int WR_LAT        = WR_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [CNT_W-1:0]         taps,
    input  logic [CNT_W-1:0]         outputs,
    input  logic                     mp_en,
    input  logic [MEM_ADDR_W-1:0]    rd_base,
    input  logic [MEM_ADDR_W-1:0]    rd_incr,
    input  logic [MEM_ADDR_W-1:0]    rd_shift,
    input  logic [VWRITE_ADDR_W-1:0] wr_base,
    output logic                     busy,
    output logic                     done,
    output logic                     vread_enB,
    output logic [MEM_ADDR_W-1:0]    vread_addrB,
    output logic                     ld_acc,
    output logic                     ld_res,
    output logic                     ld_mp,
    output logic                     vwrite_enB,
    output logic [VWRITE_ADDR_W-1:0] vwrite_addrB
);
    state_e                   state_q;
    logic                     busy_q, done_q, rd_en_q, mp_q;
    logic [CNT_W-1:0]         taps_q, outs_q, k_q, j_q;
    logic [MEM_ADDR_W-1:0]    incr_q, shift_q, addr_q, row_q;
    logic [VWRITE_ADDR_W-1:0] wr_addr_q;

    logic last_tap, last_acc, win_end;
    tag_t tag_in, tag_out;
    logic [1:0] wp_in, wp_out;

    assign last_tap = (k_q == taps_q - CNT_W'(1));
    assign last_acc = (j_q == outs_q - CNT_W'(1));
    assign win_end  = (j_q[MP_IDX_W-1:0] == MP_IDX_W'(MP_WIN - 1));

    always_comb begin
        tag_in     = '0;
        tag_in.acc = rd_en_q & (k_q == '0);
        tag_in.res = rd_en_q & last_tap;
        tag_in.mp  = tag_in.res & mp_q & (j_q[MP_IDX_W-1:0] == '0);
        tag_in.wr  = tag_in.res & (~mp_q | win_end | last_acc);
        tag_in.fin = tag_in.res & last_acc;
    end

    xyolo_ctrl_dly #(.DEPTH(RD_LAT), .WIDTH($bits(tag_t))) u_tag_dly (
        .clk (clk),
        .rst (rst),
        .d_i (tag_in),
        .q_o (tag_out)
    );

    assign wp_in = {tag_out.fin, tag_out.wr};

    xyolo_ctrl_dly #(.DEPTH(WR_LAT), .WIDTH(2)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d_i (wp_in),
        .q_o (wp_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            mp_q      <= 1'b0;
            taps_q    <= '0;
            outs_q    <= '0;
            k_q       <= '0;
            j_q       <= '0;
            incr_q    <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            wr_addr_q <= '0;
        end else begin
            if (wp_out[0]) wr_addr_q <= wr_addr_q + VWRITE_ADDR_W'(1);
            case (state_q)
                S_IDLE: if (run) begin
                    taps_q    <= taps;
                    outs_q    <= outputs;
                    mp_q      <= mp_en;
                    incr_q    <= rd_incr;
                    shift_q   <= rd_shift;
                    addr_q    <= rd_base;
                    row_q     <= rd_base;
                    k_q       <= '0;
                    j_q       <= '0;
                    wr_addr_q <= wr_base;
                    if (taps == '0 || outputs == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (last_tap) begin
                        k_q    <= '0;
                        j_q    <= j_q + CNT_W'(1);
                        row_q  <= row_q + shift_q;
                        addr_q <= row_q + shift_q;
                        if (last_acc) begin
                            rd_en_q <= 1'b0;
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        k_q    <= k_q + CNT_W'(1);
                        addr_q <= addr_q + incr_q;
                    end
                end
                S_DRAIN: if (wp_out[1]) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign vread_enB    = rd_en_q;
    assign vread_addrB  = addr_q;
    assign ld_acc       = tag_out.acc;
    assign ld_res       = tag_out.res;
    assign ld_mp        = tag_out.mp;
    assign vwrite_enB   = wp_out[0];
    assign vwrite_addrB = wr_addr_q;
endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// Directed bench for xyolo_write_ctrl: job table plus hand-written corner sequences.
module tb_xyolo_write_ctrl;
    localparam int MEM_ADDR_W = 11, VWRITE_ADDR_W = 8, CNT_W = 12;

    logic clk, rst, run, mp_en;
    logic [CNT_W-1:0] taps, outputs;
    logic [MEM_ADDR_W-1:0] rd_base, rd_incr, rd_shift;
    logic [VWRITE_ADDR_W-1:0] wr_base;
    logic busy, done, vread_enB, ld_acc, ld_res, ld_mp, vwrite_enB;
    logic [MEM_ADDR_W-1:0] vread_addrB;
    logic [VWRITE_ADDR_W-1:0] vwrite_addrB;

    xyolo_write_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .taps(taps), .outputs(outputs), .mp_en(mp_en),
        .rd_base(rd_base), .rd_incr(rd_incr), .rd_shift(rd_shift), .wr_base(wr_base),
        .busy(busy), .done(done), .vread_enB(vread_enB), .vread_addrB(vread_addrB),
        .ld_acc(ld_acc), .ld_res(ld_res), .ld_mp(ld_mp),
        .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, acc_cyc = 0;
    int rd_a[$], rd_c[$], wr_a[$], wr_c[$], acc_c[$], res_c[$];
    int mp_n = 0, both_n = 0, busy_n = 0, done_c = -1;

    always @(negedge clk) begin
        cyc++;
        if (vread_enB) begin rd_a.push_back(int'(vread_addrB)); rd_c.push_back(cyc); end
        if (vwrite_enB) begin wr_a.push_back(int'(vwrite_addrB)); wr_c.push_back(cyc); end
        if (ld_acc) acc_c.push_back(cyc);
        if (ld_res) res_c.push_back(cyc);
        if (ld_mp) mp_n++;
        if (ld_acc && ld_res) both_n++;
        if (busy) busy_n++;
        if (done && done_c < 0) done_c = cyc;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_c.delete();
        acc_c.delete(); res_c.delete();
        mp_n = 0; both_n = 0; busy_n = 0; done_c = -1;
    endtask

    // Pulses run for one cycle; returns #1 after the accepting edge.
    task automatic start(input int t, input int o, input int m, input int b,
                         input int inc, input int sh, input int wb);
        @(posedge clk); #1;
        taps = t[CNT_W-1:0]; outputs = o[CNT_W-1:0]; mp_en = m[0];
        rd_base = b[MEM_ADDR_W-1:0]; rd_incr = inc[MEM_ADDR_W-1:0];
        rd_shift = sh[MEM_ADDR_W-1:0]; wr_base = wb[VWRITE_ADDR_W-1:0];
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        clear_mon();
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin @(negedge clk); n++; end
        if (!done) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic int qf(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction
    function automatic int ql(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    typedef struct {
        int taps, outs, mp, base, incr, shift, wb;
        int e_rd, e_rf, e_rl, e_wr, e_wf, e_wl, e_mp;
    } vec_t;
    vec_t tv[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rd[6];
        int n;
        //          taps outs mp base incr shift wb | rd rf rl wr wf wl mp
        tv[0] = '{3, 2, 0,   10, 1,   5,   0,   6,   10,   17, 2, 0,   1, 0};
        tv[1] = '{1, 6, 1,  100, 3,   2,   7,   6,  100,  110, 2, 7,   8, 2};
        tv[2] = '{4, 2, 0, 2046, 1,   4, 255,   8, 2046,    5, 2, 255, 0, 0};
        tv[3] = '{2, 5, 1,    0, 1,  16,  20,  10,    0,   65, 2, 20, 21, 2};
        tv[4] = '{4, 8, 1,  500, 7, 100,   3,  32,  500, 1221, 2, 3,   4, 2};

        rst = 1'b1; run = 1'b0; taps = '0; outputs = '0; mp_en = 1'b0;
        rd_base = '0; rd_incr = '0; rd_shift = '0; wr_base = '0;
        #12;
        chk("reset_outputs", int'({busy, done, vread_enB, ld_acc, ld_res, ld_mp, vwrite_enB}), 0);
        chk("reset_addrs", int'(vread_addrB) + int'(vwrite_addrB), 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start(tv[i].taps, tv[i].outs, tv[i].mp, tv[i].base, tv[i].incr, tv[i].shift, tv[i].wb);
            wait_done();
            n = tv[i].taps * tv[i].outs;
            chk($sformatf("v%0d_reads", i), rd_a.size(), tv[i].e_rd);
            chk($sformatf("v%0d_rd_first", i), qf(rd_a), tv[i].e_rf);
            chk($sformatf("v%0d_rd_last", i), ql(rd_a), tv[i].e_rl);
            chk($sformatf("v%0d_rd_span", i), ql(rd_c) - qf(rd_c), n - 1);
            chk($sformatf("v%0d_first_rd_cyc", i), qf(rd_c), acc_cyc + 1);
            chk($sformatf("v%0d_writes", i), wr_a.size(), tv[i].e_wr);
            chk($sformatf("v%0d_wr_first", i), qf(wr_a), tv[i].e_wf);
            chk($sformatf("v%0d_wr_last", i), ql(wr_a), tv[i].e_wl);
            chk($sformatf("v%0d_acc_n", i), acc_c.size(), tv[i].outs);
            chk($sformatf("v%0d_res_n", i), res_c.size(), tv[i].outs);
            chk($sformatf("v%0d_mp_n", i), mp_n, tv[i].e_mp);
            chk($sformatf("v%0d_latency", i), ql(wr_c) - qf(rd_c), n + 4);
            chk($sformatf("v%0d_done_delay", i), done_c - ql(wr_c), 1);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, n + 5);
        end

        // Exact read stream and strobe/write timing for the basic job.
        exp_rd = '{10, 11, 12, 15, 16, 17};
        start(3, 2, 0, 10, 1, 5, 0);
        wait_done();
        for (int i = 0; i < 6; i++)
            chk($sformatf("seq_rd%0d", i), (rd_a.size() > i) ? rd_a[i] : -1, exp_rd[i]);
        chk("seq_acc0", qf(acc_c) - qf(rd_c), 2);
        chk("seq_acc1", ql(acc_c) - qf(rd_c), 5);
        chk("seq_res0", qf(res_c) - qf(rd_c), 4);
        chk("seq_res1", ql(res_c) - qf(rd_c), 7);
        chk("seq_wr0", qf(wr_c) - qf(rd_c), 7);
        chk("seq_wr1", ql(wr_c) - qf(rd_c), 10);

        // taps=1: ld_acc and ld_res coincide on every accumulation.
        start(1, 6, 1, 0, 0, 1, 7);
        wait_done();
        chk("t1_acc_res_same", both_n, 6);

        // Degenerate jobs.
        start(0, 3, 0, 0, 1, 1, 0);
        repeat (4) @(negedge clk);
        chk("taps0_done_cyc", done_c, acc_cyc + 1);
        chk("taps0_activity", rd_a.size() + wr_a.size() + acc_c.size() + res_c.size() + busy_n, 0);
        start(3, 0, 1, 0, 1, 1, 0);
        repeat (4) @(negedge clk);
        chk("outs0_done_cyc", done_c, acc_cyc + 1);
        chk("outs0_activity", rd_a.size() + wr_a.size() + acc_c.size() + res_c.size() + busy_n, 0);

        // run during ISSUE is ignored.
        start(3, 2, 0, 10, 1, 5, 0);
        repeat (2) @(posedge clk);
        #1; run = 1'b1; taps = 1; outputs = 1; wr_base = 50;
        @(posedge clk); #1 run = 1'b0;
        wait_done();
        chk("ign_writes", wr_a.size(), 2);
        chk("ign_wr_first", qf(wr_a), 0);
        chk("ign_reads", rd_a.size(), 6);

        // run after done clears done and starts.
        start(2, 1, 0, 40, 2, 0, 9);
        chk("rerun_done_low", int'(done), 0);
        chk("rerun_busy", int'(busy), 1);
        wait_done();
        chk("rerun_writes", wr_a.size(), 1);
        chk("rerun_wr_addr", qf(wr_a), 9);
        chk("rerun_rd_last", ql(rd_a), 42);

        // Asynchronous reset mid-ISSUE.
        start(4, 4, 0, 0, 1, 4, 0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", int'({busy, done, vread_enB, ld_acc, ld_res, ld_mp, vwrite_enB}), 0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_no_writes", wr_a.size(), 0);
        chk("rst_no_reads", rd_a.size(), 0);
        chk("rst_done_low", done_c, -1);
        start(3, 2, 0, 10, 1, 5, 0);
        wait_done();
        chk("post_rst_writes", wr_a.size(), 2);
        chk("post_rst_wr_last", ql(wr_a), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
